// File: rtl/game_pkg.sv
// game_pkg: shared game encodings and timing defaults
// Player state encodings, player health/timer defaults and enemy controller timing constants.
package game_pkg;
  typedef enum logic [2:0] {
    PS_IDLE  = 3'b001,
    PS_ALIVE = 3'b010,
    PS_HIT   = 3'b100,
    PS_DEAD  = 3'b111
  } player_state_t;
  localparam int DEF_MAX_HEALTH   = 4;
  localparam int DEF_INVULN_TICKS = 100;
  localparam int DEF_REGEN_TICKS  = 300;
  localparam int ENEMY_MOVE_TICKS      = 20;
  localparam int ENEMY_ATTACK_COOLDOWN = 50;
endpackage

// File: rtl/player_health_controller_if.sv
// player_health_controller_if: enemy attack input and player status bundle
// master: game side driving tick/start/enemy_attack and observing status
// slave:  player_health_controller
interface player_health_controller_if;
  logic       tick;
  logic       start;
  logic       enemy_attack;
  logic [2:0] player_state;
  logic [2:0] player_health;
  logic       damage_flash;
  logic       game_over;
  logic       hit_pulse;
  logic [7:0] hits_taken;
  modport master (
    output tick, start, enemy_attack,
    input  player_state, player_health, damage_flash, game_over, hit_pulse, hits_taken
  );
  modport slave (
    input  tick, start, enemy_attack,
    output player_state, player_health, damage_flash, game_over, hit_pulse, hits_taken
  );
endinterface

// File: rtl/player_health_controller_tick.sv
// tick_timer: tick-enabled up counter with clear and terminal-count flag
// clk, rst_n (async active-low); en: count one step; clr: return to 0 (wins over en);
// tc: count equals TERM
module tick_timer #(
  parameter int TERM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = $clog2(TERM + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(TERM);
endmodule

// File: rtl/player_health_controller.sv
// player_health_controller: player health, invulnerability window and game-over tracking
// Ports: clk, rst_n (async active-low), bus (player_health_controller_if.slave:
//  tick/start/enemy_attack in; player_state/player_health/damage_flash/game_over/
//  hit_pulse/hits_taken out). Optional health regeneration: define PLAYER_REGEN_EN.
module player_health_controller
  import game_pkg::*;
#(
  parameter int MAX_HEALTH   = DEF_MAX_HEALTH,
  parameter int INVULN_TICKS = DEF_INVULN_TICKS,
  parameter int REGEN_TICKS  = DEF_REGEN_TICKS
) (
  input logic clk,
  input logic rst_n,
  player_health_controller_if.slave bus
);
  localparam logic [2:0] MAXH = 3'(MAX_HEALTH);
  if (MAX_HEALTH < 1 || MAX_HEALTH > 7 || INVULN_TICKS < 1 || REGEN_TICKS < 1) begin : g_bad_cfg
    $error("player_health_controller: invalid parameters");
  end
  player_state_t state, nxt;
  logic [2:0] health, nhealth;
  logic [7:0] hits, nhits;
  logic hp, nhp, inv_tc, regen;
  // inv timer runs only while HIT and is zeroed on every tick that does not stay in HIT
  tick_timer #(.TERM(INVULN_TICKS - 1)) u_inv (
    .clk(clk),
    .rst_n(rst_n),
    .en(bus.tick & (state == PS_HIT)),
    .clr(bus.tick & (nxt != PS_HIT)),
    .tc(inv_tc)
  );
`ifdef PLAYER_REGEN_EN
  logic regen_tc;
  // regen timer measures uninterrupted ALIVE ticks below full health
  tick_timer #(.TERM(REGEN_TICKS - 1)) u_regen (
    .clk(clk),
    .rst_n(rst_n),
    .en(bus.tick & (state == PS_ALIVE)),
    .clr(bus.tick & ((state != PS_ALIVE) | bus.enemy_attack | (health == MAXH) | regen_tc)),
    .tc(regen_tc)
  );
  assign regen = regen_tc & (health < MAXH) & ~bus.enemy_attack & (state == PS_ALIVE);
`else
  assign regen = 1'b0;
`endif
  always_comb begin
    nxt = state;
    nhealth = health;
    nhits = hits;
    nhp = 1'b0;
    if (bus.tick)
      case (state)
        PS_IDLE, PS_DEAD:
          if (bus.start) begin
            nxt = PS_ALIVE;
            nhealth = MAXH;
            nhits = '0;
          end
        PS_ALIVE:
          if (bus.enemy_attack) begin
            nhealth = (health == 3'd0) ? 3'd0 : health - 3'd1;
            nhits = (hits == 8'hff) ? hits : hits + 8'd1;
            nhp = 1'b1;
            nxt = (nhealth == 3'd0) ? PS_DEAD : PS_HIT;
          end else if (regen) nhealth = health + 3'd1;
        PS_HIT: if (inv_tc) nxt = PS_ALIVE;
        default: nxt = PS_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= PS_IDLE;
      health <= '0;
      hits <= '0;
      hp <= 1'b0;
    end else begin
      state <= nxt;
      health <= nhealth;
      hits <= nhits;
      hp <= nhp;
    end
  assign bus.player_state = state;
  assign bus.player_health = health;
  assign bus.damage_flash = state == PS_HIT;
  assign bus.game_over = state == PS_DEAD;
  assign bus.hit_pulse = hp;
  assign bus.hits_taken = hits;
endmodule

// File: tb/tb_player_health_controller.sv
// tb_player_health_controller: directed bench with a tick-level behavioural model
module tb_player_health_controller;
  localparam int MAXH = 4, INV = 100, REG = 300;
  localparam logic [2:0] S_IDLE = 3'b001, S_ALIVE = 3'b010, S_HIT = 3'b100, S_DEAD = 3'b111;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0;
  int n;
  player_health_controller_if bus ();
  player_health_controller dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [2:0] m_state, m_health;
  int m_hits, m_inv_left, m_alive_run;
  logic m_hp;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_state <= S_IDLE;
      m_health <= 3'd0;
      m_hits <= 0;
      m_inv_left <= 0;
      m_alive_run <= 0;
      m_hp <= 1'b0;
    end else begin
      m_hp <= 1'b0;
      if (bus.tick) begin
        if (m_state == S_IDLE || m_state == S_DEAD) begin
          if (bus.start) begin
            m_state <= S_ALIVE;
            m_health <= 3'(MAXH);
            m_hits <= 0;
            m_alive_run <= 0;
          end
        end else if (m_state == S_ALIVE) begin
          if (bus.enemy_attack) begin
            m_health <= m_health - 3'd1;
            m_hits <= (m_hits < 255) ? m_hits + 1 : 255;
            m_hp <= 1'b1;
            m_alive_run <= 0;
            m_inv_left <= INV;
            m_state <= (m_health == 3'd1) ? S_DEAD : S_HIT;
          end else begin
`ifdef PLAYER_REGEN_EN
            if (m_health < 3'(MAXH)) begin
              if (m_alive_run == REG - 1) begin
                m_health <= m_health + 3'd1;
                m_alive_run <= 0;
              end else m_alive_run <= m_alive_run + 1;
            end else m_alive_run <= 0;
`endif
          end
        end else if (m_state == S_HIT) begin
          m_inv_left <= m_inv_left - 1;
          if (m_inv_left == 1) begin
            m_state <= S_ALIVE;
            m_alive_run <= 0;
          end
        end
      end
    end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n) begin
      chk("model_state", int'(bus.player_state), int'(m_state));
      chk("model_health", int'(bus.player_health), int'(m_health));
      chk("model_hits", int'(bus.hits_taken), m_hits);
      chk("model_hit_pulse", int'(bus.hit_pulse), int'(m_hp));
      chk("model_flash", int'(bus.damage_flash), int'(m_state == S_HIT));
      chk("model_game_over", int'(bus.game_over), int'(m_state == S_DEAD));
    end
  task automatic tk(input logic st, input logic at);
    @(posedge clk); #1;
    bus.tick = 1'b1;
    bus.start = st;
    bus.enemy_attack = at;
    @(posedge clk); #1;
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.enemy_attack = 1'b0;
  endtask
  task automatic wait_hit(output int cnt);
    cnt = 0;
    while (bus.damage_flash && cnt < 200) begin
      tk(1'b0, 1'b0);
      cnt++;
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    bus.tick = 1'b0;
    bus.start = 1'b0;
    bus.enemy_attack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(bus.player_state), 1);
    chk("rst_health", int'(bus.player_health), 0);
    chk("rst_hits", int'(bus.hits_taken), 0);
    chk("rst_flags", int'({bus.damage_flash, bus.game_over, bus.hit_pulse}), 0);
    rst_n = 1'b1;
    tk(1'b1, 1'b0);
    chk("start_state", int'(bus.player_state), 2);
    chk("start_health", int'(bus.player_health), 4);
    chk("start_hits", int'(bus.hits_taken), 0);
    chk("start_flags", int'({bus.damage_flash, bus.game_over, bus.hit_pulse}), 0);
    tk(1'b0, 1'b1);
    chk("hit_pulse", int'(bus.hit_pulse), 1);
    chk("hit_health", int'(bus.player_health), 3);
    chk("hit_state", int'(bus.player_state), 4);
    chk("hit_flash", int'(bus.damage_flash), 1);
    repeat (50) tk(1'b0, 1'b1);
    chk("inv_health", int'(bus.player_health), 3);
    chk("inv_hits", int'(bus.hits_taken), 1);
    chk("inv_flash", int'(bus.damage_flash), 1);
    wait_hit(n);
    chk("flash_remaining", n, 50);
    chk("inv_exit_state", int'(bus.player_state), 2);
    tk(1'b1, 1'b0);
    chk("start_ignored_health", int'(bus.player_health), 3);
    chk("start_ignored_hits", int'(bus.hits_taken), 1);
    repeat (3) begin
      tk(1'b0, 1'b1);
      wait_hit(n);
    end
    chk("dead_health", int'(bus.player_health), 0);
    chk("dead_state", int'(bus.player_state), 7);
    chk("dead_game_over", int'(bus.game_over), 1);
    chk("dead_hits", int'(bus.hits_taken), 4);
    repeat (10) tk(1'b0, 1'b1);
    chk("dead_hold_health", int'(bus.player_health), 0);
    chk("dead_hold_hits", int'(bus.hits_taken), 4);
    tk(1'b1, 1'b0);
    chk("restart_state", int'(bus.player_state), 2);
    chk("restart_health", int'(bus.player_health), 4);
    chk("restart_hits", int'(bus.hits_taken), 0);
    chk("restart_game_over", int'(bus.game_over), 0);
    tk(1'b0, 1'b1);
    repeat (40) tk(1'b0, 1'b0);
    chk("mid_hit_state", int'(bus.player_state), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(bus.player_state), 1);
    chk("async_rst_health", int'(bus.player_health), 0);
    chk("async_rst_hits", int'(bus.hits_taken), 0);
    chk("async_rst_flags", int'({bus.damage_flash, bus.game_over, bus.hit_pulse}), 0);
    tk(1'b1, 1'b1);
    chk("held_rst_state", int'(bus.player_state), 1);
    chk("held_rst_health", int'(bus.player_health), 0);
    rst_n = 1'b1;
    tk(1'b0, 1'b1);
    chk("idle_attack_state", int'(bus.player_state), 1);
    chk("idle_attack_hits", int'(bus.hits_taken), 0);
    tk(1'b1, 1'b0);
    tk(1'b0, 1'b1);
    wait_hit(n);
    chk("flash_ticks", n, 100);
    chk("post_rst_health", int'(bus.player_health), 3);
`ifdef PLAYER_REGEN_EN
    repeat (299) tk(1'b0, 1'b0);
    chk("regen_before", int'(bus.player_health), 3);
    tk(1'b0, 1'b0);
    chk("regen_after", int'(bus.player_health), 4);
    repeat (600) tk(1'b0, 1'b0);
    chk("regen_full_hold", int'(bus.player_health), 4);
    tk(1'b0, 1'b1);
    wait_hit(n);
    repeat (299) tk(1'b0, 1'b0);
    chk("regen_second_before", int'(bus.player_health), 3);
    tk(1'b0, 1'b1);
    chk("regen_vs_attack_health", int'(bus.player_health), 2);
    chk("regen_vs_attack_state", int'(bus.player_state), 4);
    chk("regen_vs_attack_hits", int'(bus.hits_taken), 3);
`else
    repeat (400) tk(1'b0, 1'b0);
    chk("no_regen_health", int'(bus.player_health), 3);
`endif
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
